tdc_measure_ctrl: RTL and testbench
===================================

Name: tdc_measure_ctrl

Overview:
- Sequencer for one ring-oscillator TDC channel (`enable` / `reset` in, `count` / `hasValue` out).
- Per measurement it:
  - clears the oscillator counter;
  - opens the oscillator on command;
  - closes it on a stop event or a timeout;
  - waits for the oscillator's asynchronous `hasValue`;
  - captures fine count plus coarse clk-cycle count, and presents the result on a valid/ready interface.
- Sits between the measurement front-end (start/stop events) and the result FIFO/readout logic.

Parameters:
- BIT_COUNT, 32, width of oscillator count and result_fine.
- COARSE_W, 16, width of coarse clk-cycle counter and result_coarse.
- CLEAR_CYCLES, 4, clk cycles osc_reset is held high before a run (≥1).
- SETTLE_CYCLES, 4, clk cycles waited after synchronised hasValue before sampling osc_count (≥1).
- TIMEOUT_CYCLES, 1024, maximum RUN cycles; also maximum DRAIN cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  one-cycle request to begin a measurement.
- stop_evt  in  1  one-cycle stop event, synchronous to clk.
- abort  in  1  cancel any measurement, return to IDLE.
- osc_enable  out  1  drives oscillator `enable`.
- osc_reset  out  1  drives oscillator `reset` (active-high).
- osc_count  in  BIT_COUNT  oscillator `count` (asynchronous domain).
- osc_has_value  in  1  oscillator `hasValue` (asynchronous).
- result_fine  out  BIT_COUNT  captured oscillator count.
- result_coarse  out  COARSE_W  clk cycles osc_enable was high.
- result_status  out  2  00 ok, 01 run timeout, 10 drain timeout.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n low, async):
  - state IDLE; osc_enable=0, osc_reset=1;
  - result_* = 0, result_valid=0, busy=0;
  - all counters 0; 2-flop has_value synchroniser cleared.
- All outputs are registered.
- States: IDLE → CLEAR → RUN → DRAIN → SETTLE → OUTPUT → IDLE.
- IDLE:
  - osc_reset=1, osc_enable=0.
  - cmd_start at cycle t → CLEAR at t+1; coarse counter and status cleared.
- CLEAR:
  - osc_reset=1 for exactly CLEAR_CYCLES cycles, then RUN.
  - osc_enable first high CLEAR_CYCLES+1 cycles after cmd_start.
- RUN:
  - osc_reset=0, osc_enable=1; coarse counter increments every RUN cycle, saturating at all-ones.
  - stop_evt at cycle s → DRAIN at s+1 with osc_enable=0; coarse equals the number of cycles osc_enable was high.
  - If TIMEOUT_CYCLES RUN cycles elapse without stop_evt → DRAIN, status=01.
  - stop_evt on the same cycle as the timeout: stop wins, status=00.
- DRAIN:
  - osc_enable=0, osc_reset=0; waits for synchronised has_value=1.
  - Timer restarts at DRAIN entry. TIMEOUT_CYCLES without has_value → OUTPUT with status=10, result_fine=0.
- SETTLE:
  - waits SETTLE_CYCLES, then registers osc_count into result_fine (count is static once enable is low and hasValue is set).
  - → OUTPUT.
- OUTPUT:
  - result_valid=1; result_* held stable until result_ready.
  - Handshake completes on a cycle with result_valid&result_ready → result_valid=0 and IDLE next cycle.
- cmd_start outside IDLE is ignored (no queueing, no error). stop_evt outside RUN is ignored.
- abort, any state except IDLE:
  - next cycle IDLE, osc_enable=0, osc_reset=1, result_valid=0;
  - no result produced; pending unaccepted result discarded.
  - abort with cmd_start on the same cycle in IDLE: abort wins, start ignored.
- osc_has_value is always used through the 2-flop synchroniser. osc_count is sampled only in SETTLE's final cycle.
- Timers are sized clog2(max(CLEAR_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES))+1 bits.

Test Plan:
- Normal measurement:
  - Stimulus: reset, cmd_start at t=10, stop_evt 20 cycles after osc_enable rises; oscillator model sets has_value 3 cycles after enable falls with count=0x1234.
  - Required: osc_enable high at t=15; result_coarse=20, result_fine=0x1234, status=00; result_valid held until result_ready.
- Run timeout:
  - Stimulus: TIMEOUT_CYCLES=64, no stop_evt.
  - Required: osc_enable high exactly 64 cycles; status=01, result_coarse=64.
- Drain timeout:
  - Stimulus: oscillator model never raises has_value.
  - Required: after 1024 DRAIN cycles, status=10, result_fine=0, result_valid=1.
- Backpressure and ignored commands:
  - Stimulus: result_ready low for 50 cycles; extra cmd_start/stop_evt pulses during RUN and OUTPUT.
  - Required: result stable, busy=1, no second measurement; IDLE one cycle after accept.
- Abort in each state:
  - Stimulus: abort in CLEAR, RUN, DRAIN, SETTLE and OUTPUT.
  - Required: next cycle osc_enable=0, osc_reset=1, result_valid=0, busy=0; a following cmd_start measures correctly.
- Async reset and edge timing:
  - Stimulus: reset_n low mid-RUN; separately, stop_evt on the timeout cycle.
  - Required: reset forces all outputs to reset values immediately; stop-on-timeout gives status=00, coarse=TIMEOUT_CYCLES.

Source files
------------

// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl: sequences one ring-oscillator TDC measurement and presents fine/coarse results on valid/ready
module tdc_measure_ctrl #(
    parameter int BIT_COUNT      = 32,
    parameter int COARSE_W       = 16,
    parameter int CLEAR_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_start,
    input  logic                 stop_evt,
    input  logic                 abort,
    output logic                 osc_enable,
    output logic                 osc_reset,
    input  logic [BIT_COUNT-1:0] osc_count,
    input  logic                 osc_has_value,
    output logic [BIT_COUNT-1:0] result_fine,
    output logic [COARSE_W-1:0]  result_coarse,
    output logic [1:0]           result_status,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy
);
    localparam int TMAX = (CLEAR_CYCLES > SETTLE_CYCLES)
        ? ((CLEAR_CYCLES > TIMEOUT_CYCLES) ? CLEAR_CYCLES : TIMEOUT_CYCLES)
        : ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES);
    localparam int TW = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, SETTLE, OUTPUT} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic          hv_meta, hv_s;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cmd_start ? CLEAR : IDLE;
            CLEAR:   state_n = (timer == TW'(CLEAR_CYCLES - 1)) ? RUN : CLEAR;
            RUN:     state_n = (stop_evt || timer == TW'(TIMEOUT_CYCLES - 1)) ? DRAIN : RUN;
            DRAIN:   state_n = hv_s ? SETTLE : (timer == TW'(TIMEOUT_CYCLES - 1)) ? OUTPUT : DRAIN;
            SETTLE:  state_n = (timer == TW'(SETTLE_CYCLES - 1)) ? OUTPUT : SETTLE;
            OUTPUT:  state_n = result_ready ? IDLE : OUTPUT;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            hv_meta       <= 1'b0;
            hv_s          <= 1'b0;
            osc_enable    <= 1'b0;
            osc_reset     <= 1'b1;
            result_fine   <= '0;
            result_coarse <= '0;
            result_status <= 2'b00;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= (state_n != state || state == IDLE) ? '0 : timer + TW'(1);
            hv_meta      <= osc_has_value;
            hv_s         <= hv_meta;
            osc_enable   <= state_n == RUN;
            osc_reset    <= state_n == IDLE || state_n == CLEAR;
            result_valid <= state_n == OUTPUT;
            busy         <= state_n != IDLE;
            if (state == IDLE && state_n == CLEAR) begin
                result_fine   <= '0;
                result_coarse <= '0;
                result_status <= 2'b00;
            end
            if (state == RUN) begin
                result_coarse <= result_coarse + COARSE_W'(!(&result_coarse));
                if (!stop_evt && state_n == DRAIN) result_status <= 2'b01;
            end
            if (state == DRAIN && state_n == OUTPUT) result_status <= 2'b10;
            if (state == SETTLE && state_n == OUTPUT) result_fine <= osc_count;
        end
    end
endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb_tdc_measure_ctrl: scoreboard bench for tdc_measure_ctrl with a behavioural oscillator model
module tb_tdc_measure_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b1;

    logic        cmd_start = 0, stop_evt = 0, abort = 0, result_ready = 0;
    logic        osc_enable, osc_reset, result_valid, busy;
    logic [31:0] osc_count = 0, result_fine;
    logic        osc_has_value = 0;
    logic [15:0] result_coarse;
    logic [1:0]  result_status;

    logic        cmd1 = 0, stop1 = 0, abort1 = 0, ready1 = 0;
    logic        en1, rst1, valid1, busy1;
    logic [31:0] cnt1 = 0, fine1;
    logic        hv1 = 0;
    logic [15:0] coarse1;
    logic [1:0]  status1;

    tdc_measure_ctrl u0 (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .stop_evt(stop_evt), .abort(abort),
        .osc_enable(osc_enable), .osc_reset(osc_reset), .osc_count(osc_count),
        .osc_has_value(osc_has_value), .result_fine(result_fine), .result_coarse(result_coarse),
        .result_status(result_status), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    tdc_measure_ctrl #(.TIMEOUT_CYCLES(64)) u1 (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd1), .stop_evt(stop1), .abort(abort1),
        .osc_enable(en1), .osc_reset(rst1), .osc_count(cnt1), .osc_has_value(hv1),
        .result_fine(fine1), .result_coarse(coarse1), .result_status(status1),
        .result_valid(valid1), .result_ready(ready1), .busy(busy1)
    );

    typedef struct packed {logic [31:0] f; logic [15:0] c; logic [1:0] s;} res_t;
    res_t q0[$];
    res_t q1[$];
    int total = 0, bad = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    // Oscillator: count fixed when enable falls, hasValue rises 3 cycles later unless suppressed
    logic [31:0] fv0 = 0;
    bit          nohv0 = 0;
    int          dly0 = 0, dly1 = 0;
    logic        pen0 = 0, pen1 = 0;
    always @(negedge clk) begin
        if (osc_reset) begin
            osc_has_value = 0; osc_count = 0; dly0 = 0;
        end else if (pen0 && !osc_enable) begin
            osc_count = fv0; dly0 = 3;
        end else if (dly0 > 0) begin
            dly0--;
            if (dly0 == 0 && !nohv0) osc_has_value = 1;
        end
        pen0 = osc_enable;
    end
    always @(negedge clk) begin
        if (rst1) begin
            hv1 = 0; cnt1 = 0; dly1 = 0;
        end else if (pen1 && !en1) begin
            cnt1 = 32'hABCD; dly1 = 3;
        end else if (dly1 > 0) begin
            dly1--;
            if (dly1 == 0) hv1 = 1;
        end
        pen1 = en1;
    end

    always @(negedge clk) begin : mon0
        res_t e;
        if (result_valid && result_ready) begin
            if (q0.size() == 0) chk("unexpected_result0", q0.size(), 1);
            else begin
                e = q0.pop_front();
                chk("fine0", result_fine, e.f);
                chk("coarse0", result_coarse, e.c);
                chk("status0", result_status, e.s);
            end
        end
    end
    always @(negedge clk) begin : mon1
        res_t e;
        if (valid1 && ready1) begin
            if (q1.size() == 0) chk("unexpected_result1", q1.size(), 1);
            else begin
                e = q1.pop_front();
                chk("fine1", fine1, e.f);
                chk("coarse1", coarse1, e.c);
                chk("status1", status1, e.s);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_cmd;
        cmd_start = 1; step(1); cmd_start = 0;
    endtask
    task automatic pulse_stop;
        stop_evt = 1; step(1); stop_evt = 0;
    endtask
    task automatic wait_en(input string n);
        int i = 0;
        while (!osc_enable && i < 50) begin step(1); i++; end
        chk(n, osc_enable, 1);
    endtask
    task automatic wait_valid(input string n);
        int i = 0;
        while (!result_valid && i < 3000) begin step(1); i++; end
        chk(n, result_valid, 1);
    endtask
    task automatic accept;
        result_ready = 1; step(1); result_ready = 0;
        chk("acc_valid", result_valid, 0);
        chk("acc_busy", busy, 0);
    endtask
    task automatic abort_now(input string n);
        abort = 1; step(1); abort = 0;
        chk({n, "_en"}, osc_enable, 0);
        chk({n, "_rst"}, osc_reset, 1);
        chk({n, "_valid"}, result_valid, 0);
        chk({n, "_busy"}, busy, 0);
    endtask
    task automatic measure(input int run, input logic [31:0] f, input logic [1:0] st);
        fv0 = f; nohv0 = 0;
        q0.push_back('{f: f, c: 16'(run), s: st});
        pulse_cmd;
        wait_en("m_en");
        step(run - 1);
        pulse_stop;
        wait_valid("m_valid");
        accept;
    endtask
    task automatic wait_en1(input string n);
        int i = 0;
        while (!en1 && i < 50) begin step(1); i++; end
        chk(n, en1, 1);
    endtask
    task automatic finish_u1(input string n);
        int i = 0;
        while (!valid1 && i < 300) begin step(1); i++; end
        chk(n, valid1, 1);
        ready1 = 1; step(1); ready1 = 0;
        chk({n, "_done"}, busy1, 0);
    endtask

    initial begin
        bit ok;
        int n;
        #2 reset_n = 0;
        step(2);
        chk("rst_en", osc_enable, 0);
        chk("rst_oscrst", osc_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_res", {result_fine, result_coarse, result_status}, 0);
        chk("rst_u1", {rst1, en1, busy1}, 3'b100);
        reset_n = 1;
        step(2);

        fv0 = 32'h1234;
        q0.push_back('{f: 32'h1234, c: 16'd20, s: 2'b00});
        pulse_cmd;
        chk("clr_busy", busy, 1);
        chk("clr_oscrst", osc_reset, 1);
        step(3);
        chk("clr_en_lo", osc_enable, 0);
        step(1);
        chk("run_en", osc_enable, 1);
        chk("run_oscrst", osc_reset, 0);
        step(19);
        pulse_stop;
        chk("drain_en", osc_enable, 0);
        step(9);
        chk("settle_valid_lo", result_valid, 0);
        step(1);
        chk("out_valid", result_valid, 1);
        step(5);
        chk("out_hold", result_valid, 1);
        accept;

        fv0 = 32'hDEAD; nohv0 = 1;
        q0.push_back('{f: 32'h0, c: 16'd7, s: 2'b10});
        pulse_cmd;
        wait_en("dt_en");
        step(6);
        pulse_stop;
        step(1023);
        chk("dt_valid_lo", result_valid, 0);
        step(1);
        chk("dt_valid", result_valid, 1);
        accept;

        fv0 = 32'h00C0FFEE; nohv0 = 0;
        q0.push_back('{f: 32'h00C0FFEE, c: 16'd12, s: 2'b00});
        pulse_cmd;
        wait_en("bp_en");
        step(4);
        pulse_cmd;
        step(6);
        pulse_stop;
        wait_valid("bp_valid");
        ok = 1;
        for (int i = 0; i < 50; i++) begin
            stop_evt = (i == 10);
            cmd_start = (i == 20);
            ok &= result_valid && busy && result_fine == 32'h00C0FFEE
                  && result_coarse == 16'd12 && result_status == 2'b00;
            step(1);
        end
        stop_evt = 0; cmd_start = 0;
        chk("bp_stable", ok, 1);
        accept;
        step(5);
        chk("bp_no_rerun", {busy, osc_reset}, 2'b01);

        nohv0 = 1;
        pulse_cmd;
        step(1);
        abort_now("ab_clear");
        pulse_cmd;
        wait_en("ab_run_en");
        step(3);
        abort_now("ab_run");
        pulse_cmd;
        wait_en("ab_drain_en");
        step(5);
        pulse_stop;
        step(1);
        abort_now("ab_drain");
        nohv0 = 0;
        pulse_cmd;
        wait_en("ab_settle_en");
        step(5);
        pulse_stop;
        step(7);
        abort_now("ab_settle");
        pulse_cmd;
        wait_en("ab_out_en");
        step(5);
        pulse_stop;
        wait_valid("ab_out_valid");
        abort_now("ab_out");
        measure(15, 32'h5555AAAA, 2'b00);

        pulse_cmd;
        wait_en("ar_en");
        step(5);
        #3 reset_n = 0;
        #1;
        chk("ar_en", osc_enable, 0);
        chk("ar_oscrst", osc_reset, 1);
        chk("ar_busy", busy, 0);
        chk("ar_res", {result_valid, result_coarse, result_status}, 0);
        @(posedge clk);
        #1 reset_n = 1;
        step(2);
        measure(9, 32'h0BADF00D, 2'b00);

        q1.push_back('{f: 32'hABCD, c: 16'd64, s: 2'b01});
        cmd1 = 1; step(1); cmd1 = 0;
        wait_en1("to_en");
        n = 0;
        while (en1 && n < 200) begin n++; step(1); end
        chk("to_len", n, 64);
        finish_u1("to_res");

        q1.push_back('{f: 32'hABCD, c: 16'd64, s: 2'b00});
        cmd1 = 1; step(1); cmd1 = 0;
        wait_en1("sot_en");
        step(63);
        stop1 = 1; step(1); stop1 = 0;
        chk("sot_en_lo", en1, 0);
        finish_u1("sot_res");

        step(3);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
